uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: data bits per frame (5..8).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit (>=2).
REQ-003 SHALL have parameter PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-005 SHALL have parameter STOP_BITS, default 1: number of stop bits (1 or 2).
REQ-006 SHALL have port clk, input, 1: single clock for all logic.
REQ-007 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port tx_en, input, 1: permits new frames to start.
REQ-009 SHALL have port fifo_empty, input, 1: TX FIFO empty flag.
REQ-010 SHALL have port fifo_data, input, DATA_BITS: TX FIFO registered read data.
REQ-011 SHALL have port fifo_rd_en, output, 1: one-cycle FIFO pop strobe.
REQ-012 SHALL have port tx, output, 1: serial line, idle high.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port tx_done, output, 1: one-cycle pulse at the end of each frame.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
REQ-016 IDLE->FETCH SHALL occur on an edge where tx_en=1 and fifo_empty=0.
REQ-017 fifo_rd_en SHALL be 1 only in FETCH (exactly one cycle per frame); FETCH->LOAD unconditionally.
REQ-018 LOAD SHALL capture fifo_data into the shift register (valid one edge after the pop); LOAD->START unconditionally.
REQ-019 tx SHALL be registered; with IDLE->FETCH at edge k, tx SHALL go low at edge k+2.
REQ-020 START, each DATA bit, PARITY and each stop bit SHALL each last exactly CLKS_PER_BIT cycles, timed by a baud counter cleared on every state entry.
REQ-021 Data SHALL be sent LSB first; the bit counter SHALL count 0..DATA_BITS-1, with no wrap beyond DATA_BITS-1.
REQ-022 Parity SHALL be the XOR of the captured data bits, inverted when PARITY_ODD=1; PARITY is skipped when PARITY_EN=0.
REQ-023 tx SHALL be high for STOP_BITS*CLKS_PER_BIT cycles in STOP.
REQ-024 tx_done SHALL pulse on the final cycle of STOP.
REQ-025 At the end of STOP, the FSM SHALL go to FETCH if tx_en=1 and fifo_empty=0, else to IDLE, giving back-to-back frames with 2 idle-high cycles between them.
REQ-026 Deasserting tx_en mid-frame SHALL NOT abort the frame; it only blocks the next fetch.
REQ-027 fifo_data and fifo_empty changes outside LOAD and the fetch decision SHALL be ignored.

Reset
REQ-028 While reset_n=0, outputs SHALL be: tx=1, busy=0, fifo_rd_en=0, tx_done=0, state=IDLE, counters and shift register cleared.
REQ-029 Reset asserted mid-frame SHALL drive tx high immediately (asynchronously), truncating the frame, and SHALL NOT pop the FIFO.
REQ-030 Reset deassertion SHALL be synchronous to clk; the first fetch SHALL occur no earlier than the first edge after release.

Structure
REQ-031 The state encoding and frame-format constants SHALL live in shared package uart_pkg, for reuse by the receiver.
REQ-032 The baud counter SHALL be a sub-module uart_baud_gen with inputs clk, reset_n and clear, and output tick; its counter width is $clog2(CLKS_PER_BIT).
REQ-033 uart_tx_ctrl SHALL connect directly to the existing FIFO read port, with the same clk on clk_rd.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-034 Push 0xA5 (PARITY_EN=0), tx_en=1: one fifo_rd_en pulse; tx line 0,1,0,1,0,0,1,0,1,1, each bit 4 clk long; tx_done after 40 cycles of frame.
REQ-035 PARITY_EN=1, even parity, 0xA5: parity bit=0; with PARITY_ODD=1: parity bit=1; frame is 44 cycles.
REQ-036 Push 0x00, 0xFF back-to-back: exactly 2 fifo_rd_en pulses; 2 idle-high cycles between frames; FIFO empty afterwards, busy=0.
REQ-037 tx_en dropped in the middle of the 0x3C frame with a second byte queued: first frame completes; no second pop until tx_en=1.
REQ-038 reset_n low during DATA bit 3: tx=1 in the same cycle, busy=0; after release with the FIFO non-empty, a new full frame is sent.
REQ-039 STOP_BITS=2, 0x81: tx high for 8 cycles before tx_done; fifo_empty=1 throughout idle: fifo_rd_en stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and parity helper,
// used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

   localparam logic LINE_IDLE     = 1'b1;
   localparam logic START_LVL     = 1'b0;
   localparam logic STOP_LVL      = 1'b1;
   localparam int   MAX_DATA_BITS = 8;

   // Unused upper bits must be zero so they do not disturb the XOR.
   function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] d,
                                        input logic odd);
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick marks the last clk of each CLKS_PER_BIT-long bit.
// clear restarts the period, so every FSM state starts on a full bit.
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);

   localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)            cnt <= '0;
      else if (clear || tick)  cnt <= '0;
      else                     cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: pops one byte from the TX FIFO read port (same clk as the
// FIFO's clk_rd) and serialises it as start / data LSB-first / parity / stop.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tx_en,
   input  logic                 fifo_empty,
   input  logic [DATA_BITS-1:0] fifo_data,
   output logic                 fifo_rd_en,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   localparam int BW = $clog2(DATA_BITS);

   uart_state_e                state, state_d;
   logic [DATA_BITS-1:0]       shreg, shreg_d;
   logic [BW-1:0]              bit_cnt, bit_cnt_d;
   logic [MAX_DATA_BITS-1:0]   fd_ext;
   logic [1:0]                 rst_sync;
   logic                       rst_n_s, tick, par_q, tx_d, last_data, last_stop, can_fetch;

   // Assert asynchronously, release on a clk edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync <= '0;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n_s = rst_sync[1];

   uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk     (clk),
      .reset_n (rst_n_s),
      .clear   (state_d != state),
      .tick    (tick)
   );

   assign last_data = (bit_cnt == BW'(DATA_BITS - 1));
   assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));
   assign can_fetch = tx_en && !fifo_empty;

   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) state <= ST_IDLE;
      else          state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE:   if (can_fetch) state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_LOAD;
         ST_LOAD:   state_d = ST_START;
         ST_START:  if (tick) state_d = ST_DATA;
         ST_DATA:   if (tick && last_data) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
         ST_PARITY: if (tick) state_d = ST_STOP;
         ST_STOP:   if (tick && last_stop) state_d = can_fetch ? ST_FETCH : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // tx is registered, so it is computed from the next state and next shift value.
   always_comb begin
      case (state_d)
         ST_START:  tx_d = START_LVL;
         ST_DATA:   tx_d = shreg_d[0];
         ST_PARITY: tx_d = par_q;
         default:   tx_d = STOP_LVL;
      endcase
   end

   assign fifo_rd_en = (state == ST_FETCH);
   assign busy       = (state != ST_IDLE);
   assign tx_done    = (state == ST_STOP) && tick && last_stop;

   // The bit counter serves DATA and STOP; it restarts on every state entry.
   always_comb begin
      shreg_d   = shreg;
      bit_cnt_d = bit_cnt;
      fd_ext    = '0;
      fd_ext[DATA_BITS-1:0] = fifo_data;
      if (state == ST_LOAD)                shreg_d = fifo_data;
      else if (state == ST_DATA && tick)   shreg_d = shreg >> 1;
      if (state_d != state)                bit_cnt_d = '0;
      else if (tick && (state == ST_DATA || state == ST_STOP))
                                           bit_cnt_d = bit_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         shreg   <= '0;
         bit_cnt <= '0;
         par_q   <= 1'b0;
         tx      <= LINE_IDLE;
      end else begin
         shreg   <= shreg_d;
         bit_cnt <= bit_cnt_d;
         tx      <= tx_d;
         if (state == ST_LOAD) par_q <= calc_parity(fd_ext, PARITY_ODD != 0);
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: three configurations (8N1, 8E1, 8O2) at 4 clk/bit,
// each fed by a small FIFO model, with a per-instance cycle-exact frame checker.
module tb_uart_tx_ctrl;

   localparam int CPB = 4;

   typedef struct packed { logic [7:0] d; logic par_even; } exp_t;
   typedef struct { logic [7:0] d; logic par_even; bit drain; } vec_t;

   logic clk = 1'b0, reset_n = 1'b0, tx_en = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] tx_w, busy_w, rd_w, done_w, empty_w;
   logic [7:0] mem [3][16];
   logic [3:0] wp [3];
   exp_t       sb [3][32];
   logic [4:0] sbw [3];
   int checks = 0, failures = 0;
   int pops [3], frames [3], glitches [3];

   for (genvar g = 0; g < 3; g++) begin : gi
      logic [3:0] rp = '0;
      logic [7:0] fd = '0;
      assign empty_w[g] = (rp == wp[g]);
      always @(posedge clk) if (rd_w[g]) begin fd <= mem[g][rp]; rp <= rp + 4'd1; end
      uart_tx_ctrl #(
         .DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN((g > 0) ? 1 : 0),
         .PARITY_ODD((g == 2) ? 1 : 0), .STOP_BITS((g == 2) ? 2 : 1)
      ) dut (
         .clk(clk), .reset_n(reset_n), .tx_en(tx_en), .fifo_empty(empty_w[g]),
         .fifo_data(fd), .fifo_rd_en(rd_w[g]), .tx(tx_w[g]), .busy(busy_w[g]),
         .tx_done(done_w[g])
      );
   end

   function automatic logic exp_bit(exp_t e, int b, int pen, int podd);
      if (b == 0) return 1'b0;
      if (b <= 8) return e.d[b-1];
      if (b == 9 && pen != 0) return e.par_even ^ (podd != 0);
      return 1'b1;
   endfunction

   task automatic chk(string name, int act, int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Cycle-exact frame checker: on each pop, expects 2 idle-high cycles, then the frame.
   task automatic mon(input int g, input int pen, input int podd, input int fl);
      logic [4:0] sbr = '0;
      exp_t e;
      bit ok, abort;
      int bad_i;
      logic [3:0] act, req;
      forever begin
         @(negedge clk);
         if (!reset_n) continue;
         if (!rd_w[g]) begin
            if (tx_w[g] !== 1'b1 || done_w[g] !== 1'b0) glitches[g]++;
            continue;
         end
         pops[g]++;
         e = sb[g][sbr]; sbr++;
         ok = (tx_w[g] === 1'b1) && (busy_w[g] === 1'b1);
         abort = 0; bad_i = -1; act = '0; req = '0;
         @(negedge clk);
         if (!reset_n) continue;
         ok &= (tx_w[g] === 1'b1) && (rd_w[g] === 1'b0) && (busy_w[g] === 1'b1);
         for (int i = 0; i < fl && !abort; i++) begin
            @(negedge clk);
            if (!reset_n) abort = 1;
            else if (tx_w[g] !== exp_bit(e, i / CPB, pen, podd) || done_w[g] !== (i == fl - 1) ||
                     busy_w[g] !== 1'b1 || rd_w[g] !== 1'b0) begin
               if (ok) begin
                  bad_i = i;
                  act = {tx_w[g], done_w[g], busy_w[g], rd_w[g]};
                  req = {exp_bit(e, i / CPB, pen, podd), (i == fl - 1), 1'b1, 1'b0};
               end
               ok = 0;
            end
         end
         if (!abort) begin
            frames[g]++;
            checks++;
            if (!ok) begin
               failures++;
               $display("FAIL frame inst%0d data=%h cycle=%0d: got tx/done/busy/rd=%b, required %b",
                        g, e.d, bad_i, act, req);
            end
         end
      end
   endtask

   task automatic tick_n(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(logic [7:0] d, logic pe);
      for (int g = 0; g < 3; g++) begin
         sb[g][sbw[g]] = '{d: d, par_even: pe};
         sbw[g]++;
         mem[g][wp[g]] = d;
         wp[g]++;
      end
   endtask

   task automatic wait_idle(string name, bit need_empty);
      int n = 0;
      tick_n(3);
      while ((busy_w != 3'b000 || (need_empty && empty_w != 3'b111)) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk({name, " idle in time"}, int'(n < 400), 1);
   endtask

   initial begin
      vec_t vt [7];
      int n;
      for (int g = 0; g < 3; g++) begin
         wp[g] = '0; sbw[g] = '0; pops[g] = 0; frames[g] = 0; glitches[g] = 0;
      end
      fork
         mon(0, 0, 0, 40);
         mon(1, 1, 0, 44);
         mon(2, 1, 1, 48);
      join_none
      vt = '{'{8'hA5, 1'b0, 1'b1}, '{8'h00, 1'b0, 1'b0}, '{8'hFF, 1'b0, 1'b1},
             '{8'h01, 1'b1, 1'b0}, '{8'h80, 1'b1, 1'b0}, '{8'h07, 1'b1, 1'b0},
             '{8'h5B, 1'b1, 1'b1}};

      tick_n(2);
      chk("reset tx", tx_w, 3'b111);
      chk("reset busy", busy_w, 0);
      chk("reset rd_en", rd_w, 0);
      chk("reset tx_done", done_w, 0);
      reset_n = 1'b1;
      tx_en   = 1'b1;
      tick_n(12);
      chk("empty fifo no pop", pops[0] + pops[1] + pops[2], 0);

      for (int i = 0; i < 7; i++) begin
         push(vt[i].d, vt[i].par_even);
         if (vt[i].drain) wait_idle($sformatf("vec%0d", i), 1'b1);
      end
      for (int g = 0; g < 3; g++) chk($sformatf("pops after table inst%0d", g), pops[g], 7);

      // tx_en dropped mid-frame: current frame finishes, queued byte stays.
      push(8'h3C, 1'b0);
      push(8'h81, 1'b0);
      tick_n(20);
      tx_en = 1'b0;
      wait_idle("tx_en drop", 1'b0);
      tick_n(20);
      for (int g = 0; g < 3; g++) chk($sformatf("held pop inst%0d", g), pops[g], 8);
      chk("queued byte held", empty_w, 0);
      tx_en = 1'b1;
      wait_idle("tx_en resume", 1'b1);
      for (int g = 0; g < 3; g++) chk($sformatf("resume pop inst%0d", g), pops[g], 9);

      // Reset during DATA bit 3 of 0xA5, with 0x5B still queued.
      push(8'hA5, 1'b0);
      push(8'h5B, 1'b1);
      n = 0;
      while (!rd_w[0] && n < 20) begin @(negedge clk); n++; end
      chk("fetch before reset", rd_w[0], 1);
      tick_n(19);
      chk("data bit3 level", tx_w, 3'b000);
      #1 reset_n = 1'b0;
      #1;
      chk("async reset tx", tx_w, 3'b111);
      chk("async reset busy", busy_w, 0);
      chk("async reset rd_en", rd_w, 0);
      tick_n(3);
      reset_n = 1'b1;
      wait_idle("post reset", 1'b1);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("final pops inst%0d", g), pops[g], 11);
         chk($sformatf("full frames inst%0d", g), frames[g], 10);
         chk($sformatf("idle line glitches inst%0d", g), glitches[g], 0);
      end
      chk("final busy", busy_w, 0);
      chk("final empty", empty_w, 3'b111);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
